// File: rtl/agc_io_pkg.sv
// Shared types and constants for the AGC input-channel loader.
package agc_io_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned DATA_W         = 15;
    localparam int unsigned CH_W           = 3;
    localparam int unsigned NUM_CH_DEFAULT = 6;
    localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [CH_W-1:0] {
        CH_VERB = 3'd0,
        CH_NOUN,
        CH_G,
        CH_RA,
        CH_RB,
        CH_ATX
    } io_ch_t;

    typedef enum logic [2:0] {
        IDLE,
        CH,
        HI,
        LO,
        CK
    } parse_state_t;

endpackage

// File: rtl/io_input_loader_if.sv
// Byte-stream valid/ready link feeding the input loader.
interface io_input_loader_if;
    import agc_io_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);

endinterface

// File: rtl/io_frame_parser.sv
// Five-byte channel frame parser: FSM, running checksum and in-frame idle timeout.
// Write/abort strobes are combinational so the owner can act on the same edge.
module io_frame_parser
    import agc_io_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [BYTE_W-1:0] HEADER         = HEADER_DEFAULT,
    parameter int unsigned       NUM_CH         = NUM_CH_DEFAULT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_xfer,
    input  logic [BYTE_W-1:0] i_byte,
    output logic              o_wr_valid_c,
    output logic [CH_W-1:0]   o_wr_ch_c,
    output logic [DATA_W-1:0] o_wr_data_c,
    output logic              o_abort_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    parse_state_t      r_state, w_state_nxt;
    logic [CH_W-1:0]   r_ch,    w_ch_nxt;
    logic [DATA_W-1:0] r_data,  w_data_nxt;
    logic [BYTE_W-1:0] r_csum,  w_csum_nxt;
    logic [CNT_W-1:0]  r_idle,  w_idle_nxt;
    logic              w_timeout;

    // Idle edge that would bring the counter up to the limit aborts the frame
    assign w_timeout = (r_state != IDLE) && !i_xfer &&
                       (r_idle == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_data  <= '0;
            r_csum  <= '0;
            r_idle  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_data  <= w_data_nxt;
            r_csum  <= w_csum_nxt;
            r_idle  <= w_idle_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ch_nxt     = r_ch;
        w_data_nxt   = r_data;
        w_csum_nxt   = r_csum;
        w_idle_nxt   = (r_state == IDLE || i_xfer) ? '0 : r_idle + CNT_W'(1);
        o_wr_valid_c = 1'b0;
        o_abort_c    = 1'b0;
        o_wr_ch_c    = r_ch;
        o_wr_data_c  = r_data;

        if (w_timeout) begin
            o_abort_c   = 1'b1;
            w_state_nxt = IDLE;
            w_idle_nxt  = '0;
        end else if (i_xfer) begin
            case (r_state)
                IDLE: begin
                    // Anything but a header is dropped to resynchronise
                    if (i_byte == HEADER) w_state_nxt = CH;
                end
                CH: begin
                    if (i_byte[7:3] != 5'd0 || 32'(i_byte[2:0]) >= NUM_CH) begin
                        o_abort_c   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ch_nxt    = i_byte[2:0];
                        w_csum_nxt  = i_byte;
                        w_state_nxt = HI;
                    end
                end
                HI: begin
                    if (i_byte[7]) begin
                        o_abort_c   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_data_nxt[14:8] = i_byte[6:0];
                        w_csum_nxt       = r_csum ^ i_byte;
                        w_state_nxt      = LO;
                    end
                end
                LO: begin
                    w_data_nxt[7:0] = i_byte;
                    w_csum_nxt      = r_csum ^ i_byte;
                    w_state_nxt     = CK;
                end
                CK: begin
                    if (i_byte == r_csum) o_wr_valid_c = 1'b1;
                    else                  o_abort_c    = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/io_input_loader.sv
// AGC input loader: parses channel frames into shadow registers and publishes
// them to the live outputs only at core-signalled commit boundaries.
module io_input_loader
    import agc_io_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [BYTE_W-1:0] HEADER         = HEADER_DEFAULT,
    parameter int unsigned       NUM_CH         = NUM_CH_DEFAULT
) (
    input  logic               clock,
    input  logic               reset_n,
    io_input_loader_if.slave   rx,
    input  logic               commit_en,
    output logic [DATA_W-1:0]  DSKY_VERB_data,
    output logic [DATA_W-1:0]  DSKY_NOUN_data,
    output logic [DATA_W-1:0]  AXI_G_data,
    output logic [DATA_W-1:0]  AXI_RA_data,
    output logic [DATA_W-1:0]  AXI_RB_data,
    output logic [DATA_W-1:0]  AXI_ATX_data,
    output logic [NUM_CH-1:0]  pending,
    output logic               frame_err,
    output logic [7:0]         err_count
);

    logic              r_rx_ready;
    logic              r_frame_err;
    logic [7:0]        r_err_count;
    logic [NUM_CH-1:0] r_pending;
    logic [DATA_W-1:0] r_shadow [NUM_CH];
    logic [DATA_W-1:0] r_live   [NUM_CH];

    logic              w_xfer;
    logic              w_wr_valid;
    logic [CH_W-1:0]   w_wr_ch;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_abort;

    assign rx.rx_ready = r_rx_ready;
    assign w_xfer      = rx.rx_valid && r_rx_ready;

    io_frame_parser #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .HEADER         (HEADER),
        .NUM_CH         (NUM_CH)
    ) u_parser (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_xfer       (w_xfer),
        .i_byte       (rx.rx_data),
        .o_wr_valid_c (w_wr_valid),
        .o_wr_ch_c    (w_wr_ch),
        .o_wr_data_c  (w_wr_data),
        .o_abort_c    (w_abort)
    );

    // Link readiness and error reporting
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rx_ready  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_rx_ready  <= 1'b1;
            r_frame_err <= w_abort;
            if (w_abort && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
    end

    // Commit reads pre-edge shadow/pending; a same-edge write re-arms its pending bit
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_pending <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_shadow[i] <= '0;
                r_live[i]   <= '0;
            end
        end else begin
            if (commit_en) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (r_pending[i]) r_live[i] <= r_shadow[i];
                end
                r_pending <= '0;
            end
            if (w_wr_valid) begin
                r_shadow[w_wr_ch]  <= w_wr_data;
                r_pending[w_wr_ch] <= 1'b1;
            end
        end
    end

    assign DSKY_VERB_data = r_live[CH_VERB];
    assign DSKY_NOUN_data = r_live[CH_NOUN];
    assign AXI_G_data     = r_live[CH_G];
    assign AXI_RA_data    = r_live[CH_RA];
    assign AXI_RB_data    = r_live[CH_RB];
    assign AXI_ATX_data   = r_live[CH_ATX];
    assign pending        = r_pending;
    assign frame_err      = r_frame_err;
    assign err_count      = r_err_count;

endmodule

// File: tb/tb_io_input_loader.sv
// Bench for io_input_loader: frame vector table plus hand-built corner sequences,
// with a queue of expected channel writes retired at each commit.
module tb_io_input_loader;
    import agc_io_pkg::*;

    localparam int unsigned TIMEOUT = 1024;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        commit_en;
    logic [14:0] DSKY_VERB_data, DSKY_NOUN_data, AXI_G_data;
    logic [14:0] AXI_RA_data, AXI_RB_data, AXI_ATX_data;
    logic [5:0]  pending;
    logic        frame_err;
    logic [7:0]  err_count;

    io_input_loader_if u_if();

    io_input_loader #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .HEADER         (8'hA5),
        .NUM_CH         (6)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rx             (u_if),
        .commit_en      (commit_en),
        .DSKY_VERB_data (DSKY_VERB_data),
        .DSKY_NOUN_data (DSKY_NOUN_data),
        .AXI_G_data     (AXI_G_data),
        .AXI_RA_data    (AXI_RA_data),
        .AXI_RB_data    (AXI_RB_data),
        .AXI_ATX_data   (AXI_ATX_data),
        .pending        (pending),
        .frame_err      (frame_err),
        .err_count      (err_count)
    );

    always #5 clock = ~clock;

    int n_checks   = 0;
    int n_errors   = 0;
    int err_pulses = 0;

    always @(negedge clock) if (frame_err === 1'b1) err_pulses++;

    typedef struct packed {
        logic [14:0] d;
        logic [2:0]  ch;
    } exp_t;

    typedef struct {
        logic [7:0]  b [6];
        int          nb;
        logic        ok;
        logic [2:0]  ch;
        logic [14:0] d;
        int          ab;
    } vec_t;

    exp_t        exp_q [$];
    logic [14:0] m_live [6];
    logic [5:0]  m_pend;
    int          m_errs;
    vec_t        vecs [8];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] live_all();
        return {6'b0, AXI_ATX_data, AXI_RB_data, AXI_RA_data,
                AXI_G_data, DSKY_NOUN_data, DSKY_VERB_data};
    endfunction

    function automatic logic [95:0] model_all();
        return {6'b0, m_live[5], m_live[4], m_live[3], m_live[2], m_live[1], m_live[0]};
    endfunction

    function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, b4, b5, input int nb,
                                input logic ok, input logic [2:0] ch,
                                input logic [14:0] d, input int ab);
        vec_t v;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4; v.b[5] = b5;
        v.nb = nb; v.ok = ok; v.ch = ch; v.d = d; v.ab = ab;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        tick();
        u_if.rx_valid = 1'b0;
    endtask

    task automatic expect_write(input logic [2:0] ch, input logic [14:0] d);
        exp_t e;
        e.ch = ch;
        e.d  = d;
        exp_q.push_back(e);
        m_pend[ch] = 1'b1;
    endtask

    task automatic count_abort();
        if (m_errs < 255) m_errs++;
    endtask

    task automatic retire_queue();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m_live[e.ch] = e.d;
        end
        m_pend = '0;
    endtask

    task automatic do_commit(input string tag);
        commit_en = 1'b1;
        tick();
        commit_en = 1'b0;
        retire_queue();
        check({tag, "_live"}, live_all(), model_all());
        check({tag, "_pend"}, 96'(pending), 96'(m_pend));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_live[i] = '0;
        m_pend = '0;
        m_errs = 0;
        exp_q.delete();
    endtask

    initial begin
        int e0;
        int c;

        reset_n       = 1'b0;
        commit_en     = 1'b0;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = 8'h00;
        model_reset();

        vecs[0] = mk(8'hA5, 8'h00, 8'h00, 8'h37, 8'h37, 8'h00, 5, 1'b1, 3'd0, 15'h0037, 0);
        vecs[1] = mk(8'hA5, 8'h02, 8'h01, 8'h23, 8'h00, 8'h00, 5, 1'b0, 3'd0, 15'h0000, 1);
        vecs[2] = mk(8'h11, 8'hA5, 8'h05, 8'h0A, 8'hBC, 8'hB3, 6, 1'b1, 3'd5, 15'h0ABC, 0);
        vecs[3] = mk(8'hA5, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00, 2, 1'b0, 3'd0, 15'h0000, 1);
        vecs[4] = mk(8'hA5, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 3, 1'b0, 3'd0, 15'h0000, 1);
        vecs[5] = mk(8'hA5, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 2, 1'b0, 3'd0, 15'h0000, 1);
        vecs[6] = mk(8'hA5, 8'h04, 8'h7F, 8'hFF, 8'h84, 8'h00, 5, 1'b1, 3'd4, 15'h7FFF, 0);
        vecs[7] = mk(8'hA5, 8'h01, 8'h12, 8'h34, 8'h27, 8'h00, 5, 1'b1, 3'd1, 15'h1234, 0);

        // Reset state
        tick();
        tick();
        check("rst_live",      live_all(), 96'd0);
        check("rst_pend",      96'(pending), 96'd0);
        check("rst_frame_err", 96'(frame_err), 96'd0);
        check("rst_err_count", 96'(err_count), 96'd0);
        check("rst_rx_ready",  96'(u_if.rx_ready), 96'd0);
        reset_n = 1'b1;
        tick();
        check("rel_rx_ready",  96'(u_if.rx_ready), 96'd1);

        // Frame vector table, each followed by a commit
        for (int k = 0; k < 8; k++) begin
            e0 = err_pulses;
            for (int j = 0; j < vecs[k].nb; j++) send_byte(vecs[k].b[j]);
            tick();
            if (vecs[k].ok) expect_write(vecs[k].ch, vecs[k].d);
            if (vecs[k].ab != 0) count_abort();
            check($sformatf("v%0d_err_pulse", k), 96'(err_pulses - e0), 96'(vecs[k].ab));
            check($sformatf("v%0d_err_count", k), 96'(err_count), 96'(m_errs));
            check($sformatf("v%0d_pend", k), 96'(pending), 96'(m_pend));
            check($sformatf("v%0d_live_hold", k), live_all(), model_all());
            do_commit($sformatf("v%0d_commit", k));
        end

        // Commit with nothing pending
        do_commit("idle_commit");

        // Two frames to one channel before commit
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h23); send_byte(8'h20);
        expect_write(3'd2, 15'h0123);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h03); send_byte(8'h45); send_byte(8'h44);
        expect_write(3'd2, 15'h0345);
        check("dup_pend", 96'(pending), 96'(m_pend));
        do_commit("dup_commit");
        check("dup_axi_g", 96'(AXI_G_data), 96'h345);

        // Timeout inside a frame, then a good frame
        e0 = err_pulses;
        send_byte(8'hA5);
        send_byte(8'h01);
        c = 0;
        while (c < int'(TIMEOUT) + 8 && frame_err !== 1'b1) begin
            tick();
            c++;
        end
        count_abort();
        check("timeout_latency", 96'(c), 96'(TIMEOUT));
        tick();
        check("timeout_pulses", 96'(err_pulses - e0), 96'd1);
        check("timeout_err_count", 96'(err_count), 96'(m_errs));
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h0F); send_byte(8'hF0); send_byte(8'hFE);
        expect_write(3'd1, 15'h0FF0);
        tick();
        check("post_timeout_pend", 96'(pending), 96'(m_pend));
        do_commit("post_timeout_commit");

        // Commit on the same edge as a checksum byte
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h55); send_byte(8'h55);
        expect_write(3'd0, 15'h0055);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h07); send_byte(8'h89);
        commit_en = 1'b1;
        send_byte(8'h8D);
        commit_en = 1'b0;
        retire_queue();
        expect_write(3'd3, 15'h0789);
        check("same_edge_ra",   96'(AXI_RA_data), 96'(m_live[3]));
        check("same_edge_live", live_all(), model_all());
        check("same_edge_pend", 96'(pending), 96'h08);
        do_commit("same_edge_next");
        check("same_edge_ra_after", 96'(AXI_RA_data), 96'h789);

        // Reset in the middle of a frame discards it
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h12);
        reset_n = 1'b0;
        tick();
        model_reset();
        check("midrst_live", live_all(), model_all());
        check("midrst_pend", 96'(pending), 96'd0);
        reset_n = 1'b1;
        tick();
        e0 = err_pulses;
        send_byte(8'h34);
        send_byte(8'h27);
        tick();
        check("midrst_no_err", 96'(err_pulses - e0), 96'd0);
        check("midrst_no_pend", 96'(pending), 96'd0);

        // Error counter saturation
        e0 = err_pulses;
        for (int k = 0; k < 260; k++) begin
            send_byte(8'hA5);
            send_byte(8'h06);
            count_abort();
        end
        tick();
        check("sat_pulses", 96'(err_pulses - e0), 96'd260);
        check("sat_err_count", 96'(err_count), 96'(m_errs));
        check("sat_live", live_all(), model_all());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
